// File: rtl/i2c_master_mb.sv
// i2c_master_mb: I2C master doing register-addressed writes and reads of up to MAX_BYTES data bytes.
// Ports:
//   clk, rst (sync, active-low)       - clock and reset
//   start, slave_addr, rw, reg_addr   - transfer request and its parameters, latched on acceptance
//   byte_count, wdata                 - number of data bytes and write payload (byte k at [8k+7:8k])
//   rdata                             - read payload (byte k at [8k+7:8k])
//   busy, done, nack                  - status: in progress, end pulse, last transfer aborted on NACK
//   scl, sda_out, sda_oe, sda_in      - bus pins; bus level = sda_oe ? sda_out : 1
module i2c_master_mb #(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [6:0]                 slave_addr,
    input  logic                       rw,
    input  logic [7:0]                 reg_addr,
    input  logic [$clog2(MAX_BYTES):0] byte_count,
    input  logic [8*MAX_BYTES-1:0]     wdata,
    output logic [8*MAX_BYTES-1:0]     rdata,
    output logic                       busy,
    output logic                       done,
    output logic                       nack,
    output logic                       scl,
    output logic                       sda_out,
    output logic                       sda_oe,
    input  logic                       sda_in
);
    localparam int BW = $clog2(MAX_BYTES) + 1;
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int DW = 8 * MAX_BYTES;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK, RESTART, ADDR_R, ADDR_R_ACK,
        WDATA, WACK, RDATA, MACK, STOP, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [BW-1:0] byte_q, byte_d, cnt_q, cnt_d;
    logic [7:0]    sh_q, sh_d, reg_q, reg_d;
    logic [6:0]    addr_q, addr_d;
    logic          rw_q, rw_d, samp_q, samp_d, nack_q, nack_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic          qend, sample, bit_end, last, mid, in_byte;

    assign qend    = qcnt_q == CW'(CLK_DIV - 1);
    assign sample  = qend && qtr_q == 2'd1;
    assign bit_end = qend && qtr_q == 2'd3;
    assign last    = byte_q == cnt_q - BW'(1);
    assign mid     = qtr_q == 2'd1 || qtr_q == 2'd2;
    assign in_byte = state_q inside {ADDR, REG, ADDR_R, WDATA, RDATA};

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        reg_d   = reg_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        samp_d  = samp_q;
        nack_d  = nack_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (state_q != IDLE && state_q != DONE) begin
            qcnt_d = qend ? '0 : qcnt_q + CW'(1);
            qtr_d  = qend ? qtr_q + 2'd1 : qtr_q;
        end
        if (sample) samp_d = sda_in;
        if (sample && state_q == RDATA) sh_d = {sh_q[6:0], sda_in};
        if (state_q == IDLE && start && byte_count != '0 && byte_count <= BW'(MAX_BYTES)) begin
            state_d = START;
            addr_d  = slave_addr;
            rw_d    = rw;
            reg_d   = reg_addr;
            cnt_d   = byte_count;
            wdata_d = wdata;
            nack_d  = 1'b0;
            byte_d  = '0;
        end
        if (state_q == DONE) state_d = IDLE;
        if (bit_end) begin
            // counters wrap to zero at every bit boundary, so each state starts at Q0/bit 0
            bit_d = in_byte ? bit_q + 3'd1 : 3'd0;
            if (state_q != RDATA) sh_d = {sh_q[6:0], 1'b0};
            case (state_q)
                START:      begin state_d = ADDR; sh_d = {addr_q, 1'b0}; end
                RESTART:    begin state_d = ADDR_R; sh_d = {addr_q, 1'b1}; end
                ADDR:       if (bit_q == 3'd7) state_d = ADDR_ACK;
                REG:        if (bit_q == 3'd7) state_d = REG_ACK;
                ADDR_R:     if (bit_q == 3'd7) state_d = ADDR_R_ACK;
                WDATA:      if (bit_q == 3'd7) state_d = WACK;
                RDATA:      if (bit_q == 3'd7) begin
                                state_d = MACK;
                                rdata_d[8*int'(byte_q) +: 8] = sh_q;
                            end
                ADDR_ACK:   begin state_d = REG; sh_d = reg_q; end
                REG_ACK:    begin state_d = rw_q ? RESTART : WDATA; sh_d = wdata_q[7:0]; end
                ADDR_R_ACK: state_d = RDATA;
                WACK:       if (last) state_d = STOP;
                            else begin
                                state_d = WDATA;
                                byte_d  = byte_q + BW'(1);
                                sh_d    = wdata_q[8*int'(byte_q) + 8 +: 8];
                            end
                MACK:       if (last) state_d = STOP;
                            else begin
                                state_d = RDATA;
                                byte_d  = byte_q + BW'(1);
                            end
                STOP:       state_d = DONE;
                default:    ;
            endcase
            // a released SDA in any slave-ACK slot aborts the rest of the transfer
            if (samp_q && state_q inside {ADDR_ACK, REG_ACK, ADDR_R_ACK, WACK}) begin
                state_d = STOP;
                nack_d  = 1'b1;
            end
        end
    end

    always_comb begin
        scl     = 1'b1;
        sda_out = 1'b1;
        sda_oe  = 1'b0;
        case (state_q)
            // SDA high for Q0/Q1, falls at Q2 entry while SCL is high
            START, RESTART:                           begin scl = mid; sda_oe = 1'b1; sda_out = ~qtr_q[1]; end
            ADDR, REG, ADDR_R, WDATA:                 begin scl = mid; sda_oe = 1'b1; sda_out = sh_q[7]; end
            ADDR_ACK, REG_ACK, ADDR_R_ACK, WACK, RDATA: scl = mid;
            MACK:                                     begin scl = mid; sda_oe = 1'b1; sda_out = last; end
            // SDA held low until Q2, then released while SCL stays high
            STOP:                                     begin scl = qtr_q != 2'd0; sda_oe = ~qtr_q[1]; sda_out = qtr_q[1]; end
            default:                                  ;
        endcase
    end

    assign busy  = state_q != IDLE;
    assign done  = state_q == DONE;
    assign nack  = nack_q;
    assign rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            qcnt_q  <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            reg_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            samp_q  <= 1'b0;
            nack_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            reg_q   <= reg_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            samp_q  <= samp_d;
            nack_q  <= nack_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_i2c_master_mb.sv
// tb_i2c_master_mb: table-driven bench with a bus-level slave model and byte/ACK scoreboards.
module tb_i2c_master_mb;
    localparam int CD = 1;
    localparam int MB = 4;

    logic        clk = 0, rst = 0, start = 0, rw = 0;
    logic [6:0]  slave_addr = '0;
    logic [7:0]  reg_addr = '0;
    logic [2:0]  byte_count = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy, done, nack, scl, sda_out, sda_oe, sda_in, bus, slave_low;

    logic        in_frame = 0, reading = 0, rd_pend = 0, ack_en = 1;
    int          bitn = 0, fb = 0, rd_idx = 0, scl_edges = 0;
    logic [7:0]  cur = '0;
    logic [31:0] rd_word = '0;
    logic [7:0]  exp_q[$];
    logic        mack_q[$];
    int          nvec = 0, nerr = 0;

    typedef struct {
        logic rw; logic [6:0] addr; logic [7:0] ra; int n; logic [31:0] wd; logic [31:0] rd;
        logic ack; logic poke; int ecyc; logic enack; logic [31:0] erd;
    } vec_t;
    vec_t vt[8];

    always #5 clk = ~clk;

    i2c_master_mb #(.CLK_DIV(CD), .MAX_BYTES(MB)) dut (
        .clk(clk), .rst(rst), .start(start), .slave_addr(slave_addr), .rw(rw),
        .reg_addr(reg_addr), .byte_count(byte_count), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .nack(nack), .scl(scl), .sda_out(sda_out),
        .sda_oe(sda_oe), .sda_in(sda_in)
    );

    assign bus    = (sda_oe ? sda_out : 1'b1) & ~slave_low;
    assign sda_in = bus;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // slave: ACKs written bytes in slot 8, or drives read data bits while reading
    always_comb begin
        slave_low = 1'b0;
        if (in_frame && bitn == 8 && !reading && ack_en) slave_low = 1'b1;
        if (in_frame && reading && bitn >= 0 && bitn < 8) slave_low = ~rd_word[8*rd_idx + 7 - bitn];
    end

    always @(negedge bus) if (scl === 1'b1) begin
        in_frame = 1; bitn = -1; fb = 0; reading = 0; rd_pend = 0;
    end

    always @(posedge bus) if (scl === 1'b1) in_frame = 0;

    always @(negedge scl) begin
        scl_edges++;
        if (in_frame) begin
            bitn++;
            if (bitn == 9) begin
                bitn = 0;
                if (rd_pend) begin reading = 1; rd_pend = 0; rd_idx = 0; end
            end
        end
    end

    always @(posedge scl) if (in_frame) begin
        if (bitn >= 0 && bitn < 8) cur = {cur[6:0], bus};
        else if (bitn == 8) begin
            if (reading) begin
                if (mack_q.size() == 0) begin nvec++; nerr++; $display("FAIL master_ack: unexpected ack bit %0b", bus); end
                else chk("master_ack", 32'(bus), 32'(mack_q.pop_front()));
                if (bus) reading = 0; else rd_idx++;
            end else begin
                if (fb == 0 && cur[0]) rd_pend = 1;
                if (exp_q.size() == 0) begin nvec++; nerr++; $display("FAIL sda_byte: unexpected byte %0h", cur); end
                else chk("sda_byte", 32'(cur), 32'(exp_q.pop_front()));
            end
            fb++;
        end
    end

    task automatic run(input vec_t v);
        int   cyc;
        logic seen;
        exp_q.push_back({v.addr, 1'b0});
        if (v.ack) begin
            exp_q.push_back(v.ra);
            if (v.rw) begin
                exp_q.push_back({v.addr, 1'b1});
                for (int k = 0; k < v.n; k++) mack_q.push_back(k == v.n - 1);
            end else
                for (int k = 0; k < v.n; k++) exp_q.push_back(v.wd[8*k +: 8]);
        end
        ack_en = v.ack; rd_word = v.rd;
        slave_addr = v.addr; rw = v.rw; reg_addr = v.ra; byte_count = 3'(v.n); wdata = v.wd; start = 1;
        @(posedge clk); #1 start = 0;
        chk("busy_after_accept", 32'(busy), 1);
        chk("nack_cleared", 32'(nack), 0);
        cyc = 0; seen = 0;
        while (!seen && cyc < 2000) begin
            @(posedge clk); #1 cyc++;
            if (v.poke && cyc == 30) begin start = 1; rw = ~v.rw; byte_count = 3'd2; slave_addr = 7'h00; end
            if (v.poke && cyc == 36) start = 0;
            seen = done;
        end
        chk("done_cycle", 32'(cyc), 32'(v.ecyc));
        chk("nack", 32'(nack), 32'(v.enack));
        chk("rdata", rdata, v.erd);
        chk("bytes_left", 32'(exp_q.size()), 0);
        chk("acks_left", 32'(mack_q.size()), 0);
        @(posedge clk); #1
        chk("busy_after_done", 32'(busy), 0);
        chk("done_pulse", 32'(done), 0);
        exp_q.delete(); mack_q.delete();
    endtask

    task automatic illegal(input logic [2:0] bc, input string nm);
        int e;
        slave_addr = 7'h50; rw = 0; reg_addr = 8'h10; byte_count = bc; start = 1;
        e = scl_edges;
        repeat (3) begin @(posedge clk); #1 chk(nm, 32'(busy), 0); end
        start = 0;
        chk({nm, "_scl"}, 32'(scl_edges), 32'(e));
    endtask

    initial begin
        #200000 $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{0, 7'h50, 8'h10, 2, 32'h0000BEEF, 32'h0, 1, 0, 152, 0, 32'h00000000};
        vt[1] = '{1, 7'h50, 8'h04, 3, 32'h0, 32'h00332211, 1, 0, 228, 0, 32'h00332211};
        vt[2] = '{0, 7'h3C, 8'h55, 1, 32'h000000C3, 32'h0, 0, 0, 44, 1, 32'h00332211};
        vt[3] = '{0, 7'h2A, 8'h99, 4, 32'h01020304, 32'h0, 1, 0, 224, 0, 32'h00332211};
        vt[4] = '{1, 7'h68, 8'h75, 1, 32'h0, 32'h000000A5, 1, 0, 156, 0, 32'h003322A5};
        vt[5] = '{0, 7'h11, 8'h22, 1, 32'h0000007E, 32'h0, 1, 1, 116, 0, 32'h003322A5};
        vt[6] = '{1, 7'h7F, 8'hFF, 4, 32'h0, 32'h8001FE5A, 1, 0, 264, 0, 32'h8001FE5A};
        vt[7] = '{1, 7'h12, 8'h34, 2, 32'h0, 32'h0, 0, 0, 44, 1, 32'h8001FE5A};
        rst = 0;
        repeat (3) @(posedge clk);
        #1
        chk("rst_scl", 32'(scl), 1);
        chk("rst_sda_oe", 32'(sda_oe), 0);
        chk("rst_sda_out", 32'(sda_out), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_nack", 32'(nack), 0);
        chk("rst_rdata", rdata, 0);
        rst = 1;
        @(posedge clk); #1
        illegal(3'd0, "ignore_count0");
        illegal(3'd5, "ignore_count5");
        for (int i = 0; i < 8; i++) run(vt[i]);
        // reset in the middle of the first write data byte
        exp_q.push_back(8'hA0); exp_q.push_back(8'h10);
        ack_en = 1; slave_addr = 7'h50; rw = 0; reg_addr = 8'h10; byte_count = 3'd2; wdata = 32'hBEEF; start = 1;
        @(posedge clk); #1 start = 0;
        repeat (85) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1
        chk("midrst_scl", 32'(scl), 1);
        chk("midrst_sda_oe", 32'(sda_oe), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_bytes_seen", 32'(exp_q.size()), 0);
        rst = 1; in_frame = 0; bitn = 0; exp_q.delete();
        @(posedge clk); #1
        run(vt[0]);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
